char_buffer_arbiter: RTL and testbench

//  Owns the single-port screen character RAM (COLS x ROWS ASCII codes) and shares it between
//  the video scan-out fetcher (hard priority, fixed latency) and the host/terminal write side.

---
 rtl/charbuf_pkg.sv | 15 +
 rtl/charbuf_fill_counter.sv | 31 +++
 rtl/char_buffer_arbiter.sv | 132 +++++++++++++
 tb/tb_char_buffer_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/charbuf_pkg.sv
// Shared constants for the screen character buffer: geometry, fill code and FSM encoding.
package charbuf_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 25;
  localparam int ADDR_W      = 11;
  localparam int SCREEN_SIZE = COLS * ROWS;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LINE  = 2'd2;

endpackage

// File: rtl/charbuf_fill_counter.sv
// Loadable address counter for the fill engine; done flags that the end address is current.
module charbuf_fill_counter
  import charbuf_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] end_val,
  input  logic              advance,
  output logic [ADDR_W-1:0] count,
  output logic              done
);

  logic [ADDR_W-1:0] end_addr;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count    <= '0;
      end_addr <= '0;
    end else if (load) begin
      count    <= load_val;
      end_addr <= end_val;
    end else if (advance) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == end_addr);

endmodule

// File: rtl/char_buffer_arbiter.sv
// Screen RAM port arbiter: video fetch > fill engine > host write, one access per cycle.
// Optional row clear (LINE state, clr_line/clr_row) is built only with CHARBUF_LINE_CLEAR_EN.
//
// state    | meaning
// ST_IDLE  | no fill running; host writes may be accepted
// ST_CLEAR | writing FILL_CHAR over the whole screen, stalls on vid_req
// ST_LINE  | writing FILL_CHAR over one row (CHARBUF_LINE_CLEAR_EN only)
module char_buffer_arbiter
  import charbuf_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_err,
  input  logic              clr_start,
  input  logic              clr_line,
  input  logic [4:0]        clr_row,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] SCREEN_END = ADDR_W'(SCREEN_SIZE - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LEN = ADDR_W'(SCREEN_SIZE);

  if ((2 ** ADDR_W) < SCREEN_SIZE) begin : g_addr_check
    $error("ADDR_W too small for COLS*ROWS");
  end

  logic [1:0]        state, next_state;
  logic              cnt_load, cnt_done;
  logic [ADDR_W-1:0] cnt_load_val, cnt_end_val, fill_addr;
  logic              fill_active, wr_fire, wr_in_range;

  assign fill_active = (state != ST_IDLE);
  assign clr_busy    = fill_active;
  assign wr_ready    = clr_n & ~vid_req & ~fill_active & ~clr_start;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (wr_addr < SCREEN_LEN);

`ifdef CHARBUF_LINE_CLEAR_EN
  localparam logic [4:0] ROWS_R = 5'(ROWS);
  logic [ADDR_W-1:0] line_base;
  assign line_base = ADDR_W'(clr_row) * ADDR_W'(COLS);
`else
  logic unused_line_req;
  assign unused_line_req = ^{clr_line, clr_row};
`endif

  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_end_val  = SCREEN_END;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          next_state = ST_CLEAR;
          cnt_load   = 1'b1;
        end
`ifdef CHARBUF_LINE_CLEAR_EN
        else if (clr_line && (clr_row < ROWS_R)) begin
          next_state   = ST_LINE;
          cnt_load     = 1'b1;
          cnt_load_val = line_base;
          cnt_end_val  = line_base + ADDR_W'(COLS - 1);
        end
`endif
      end
      ST_CLEAR: if (!vid_req && cnt_done) next_state = ST_IDLE;
`ifdef CHARBUF_LINE_CLEAR_EN
      ST_LINE:  if (!vid_req && cnt_done) next_state = ST_IDLE;
`endif
      default:  next_state = ST_IDLE;
    endcase
  end

  charbuf_fill_counter u_fill_counter (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .end_val  (cnt_end_val),
    .advance  (fill_active & ~vid_req),
    .count    (fill_addr),
    .done     (cnt_done)
  );

  // RAM port is driven combinationally so the synchronous RAM returns video data one cycle later.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (clr_n) begin
      if (vid_req) begin
        mem_addr = vid_addr;
      end else if (fill_active) begin
        mem_addr  = fill_addr;
        mem_we    = 1'b1;
        mem_wdata = FILL_CHAR;
      end else if (wr_fire) begin
        mem_addr  = wr_addr;
        mem_we    = wr_in_range;
        mem_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      vid_valid <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= next_state;
      vid_valid <= vid_req;
      wr_err    <= wr_fire & ~wr_in_range;
    end
  end

  assign vid_data = vid_valid ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Directed bench for char_buffer_arbiter with a behavioural synchronous screen RAM.
module tb_char_buffer_arbiter;
  import charbuf_pkg::*;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_err;
  logic              clr_start;
  logic              clr_line;
  logic [4:0]        clr_row;
  logic              clr_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0]        ram [0:2047];
  logic              bd_fill, bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [7:0]        bd_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  char_buffer_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err),
    .clr_start(clr_start), .clr_line(clr_line), .clr_row(clr_row), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Backdoor preload shares the RAM process so the array has a single writer.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    if (bd_fill) for (int i = 0; i < 2048; i++) ram[i] <= bd_val;
    if (bd_we) ram[bd_addr] <= bd_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [7:0] v);
    bd_val = v; bd_fill = 1'b1;
    tick();
    bd_fill = 1'b0;
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] v);
    bd_addr = a; bd_val = v; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  function automatic int count_not(input int lo, input int hi, input logic [7:0] v);
    int bad = 0;
    for (int i = lo; i <= hi; i++) if (ram[i] !== v) bad++;
    return bad;
  endfunction

  initial begin
    int n, bad, vcount;
    clr_n = 1'b0; vid_req = 1'b0; vid_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; clr_start = 1'b0; clr_line = 1'b0; clr_row = '0;
    bd_fill = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_val = '0;

    // reset state
    do_fill(8'h00);
    wr_valid = 1'b1; vid_addr = 11'd7;
    tick();
    @(negedge clk);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_vid_data", vid_data, 0);
    tick();
    wr_valid = 1'b0; vid_addr = '0; clr_n = 1'b1;

    // 1: three back-to-back video fetches
    bd_write(11'd5, 8'h41);
    vid_req = 1'b1; vid_addr = 11'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_mem_addr", mem_addr, 5);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_valid_before", vid_valid, (i == 0) ? 0 : 1);
      tick();
      chk("t1_valid", vid_valid, 1);
      chk("t1_data", vid_data, 8'h41);
    end
    vid_req = 1'b0;
    tick();
    chk("t1_valid_end", vid_valid, 0);

    // 2: host write blocked by video for two cycles
    vid_req = 1'b1; wr_valid = 1'b1; wr_addr = 11'd79; wr_data = 8'h42;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_ready_blocked", wr_ready, 0);
      tick();
    end
    vid_req = 1'b0;
    @(negedge clk);
    chk("t2_ready", wr_ready, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 79);
    tick();
    wr_valid = 1'b0;
    chk("t2_ram79", ram[79], 8'h42);

    // 3: full clear with no video traffic, host write held off throughout
    clr_start = 1'b1;
    @(negedge clk);
    chk("t3_ready_on_start", wr_ready, 0);
    tick();
    clr_start = 1'b0; wr_valid = 1'b1; wr_addr = 11'd10; wr_data = 8'h77;
    n = 0; bad = 0;
    while (clr_busy && n < 3000) begin
      @(negedge clk);
      if (wr_ready) bad++;
      tick();
      n++;
    end
    wr_valid = 1'b0;
    chk("t3_busy_cycles", n, 2000);
    chk("t3_ready_during", bad, 0);
    chk("t3_busy_end", clr_busy, 0);
    chk("t3_ram_filled", count_not(0, 1999, 8'h20), 0);
    chk("t3_ram79", ram[79], 8'h20);

    // 4: clear interleaved with video every other cycle
    bd_write(11'd2047, 8'h5A);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0; vid_addr = 11'd2047;
    n = 0; bad = 0; vcount = 0;
    while (clr_busy && n < 6000) begin
      vid_req = (n % 2 == 0);
      tick();
      if (vid_valid) begin
        vcount++;
        if (vid_data !== 8'h5A) bad++;
      end
      n++;
    end
    vid_req = 1'b0;
    chk("t4_busy_cycles", n, 4000);
    chk("t4_vid_count", vcount, 2000);
    chk("t4_vid_data", bad, 0);
    chk("t4_ram_filled", count_not(0, 1999, 8'h20), 0);
    chk("t4_ram2047", ram[2047], 8'h5A);

    // 5: out-of-range host write, then reset in the middle of a clear
    wr_valid = 1'b1; wr_addr = 11'd2000; wr_data = 8'h99;
    @(negedge clk);
    chk("t5_ready", wr_ready, 1);
    chk("t5_mem_we", mem_we, 0);
    tick();
    wr_valid = 1'b0;
    chk("t5_err_pulse", wr_err, 1);
    tick();
    chk("t5_err_clear", wr_err, 0);
    chk("t5_ram2000", ram[2000], 8'h00);

    do_fill(8'hAA);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    chk("t5_busy_mid", clr_busy, 1);
    clr_n = 1'b0;
    tick();
    chk("t5_busy_rst", clr_busy, 0);
    clr_n = 1'b1;
    tick();
    chk("t5_busy_after", clr_busy, 0);
    chk("t5_ram99", ram[99], 8'h20);
    chk("t5_ram100", ram[100], 8'hAA);
    chk("t5_ram1500", ram[1500], 8'hAA);

`ifdef CHARBUF_LINE_CLEAR_EN
    // 6: single-row clear of the last row, then an out-of-range row
    do_fill(8'hAA);
    clr_row = 5'd24; clr_line = 1'b1;
    tick();
    clr_line = 1'b0;
    n = 0;
    while (clr_busy && n < 200) begin
      tick();
      n++;
    end
    chk("t6_busy_cycles", n, 80);
    chk("t6_row_filled", count_not(1920, 1999, 8'h20), 0);
    chk("t6_rest_kept", count_not(0, 1919, 8'hAA), 0);
    clr_row = 5'd25; clr_line = 1'b1;
    @(negedge clk);
    chk("t6_row25_we", mem_we, 0);
    tick();
    clr_line = 1'b0;
    chk("t6_row25_busy", clr_busy, 0);
`else
    // 6: row clear request is ignored in this build
    clr_row = 5'd24; clr_line = 1'b1;
    tick();
    clr_line = 1'b0;
    chk("t6_line_ignored", clr_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
